buf_que_flush: RTL

Parametrised successor to the pipeline's small circular buffer queue, for instruction-fetch and store buffering.
- Adds an occupancy count, programmable almost-full and almost-empty flags, and a second-entry lookahead port.
- Adds a single-cycle flush for branch mispredicts, pass-through read+write when full, and sticky overflow/underflow error flags.
- Sits between a producer stage and a consumer stage on the single CPU clock.

---
 rtl/buf_que_flush.sv | 122 ++++++++++++
 1 files changed

// File: rtl/buf_que_flush.sv
// Circular buffer queue with occupancy count, almost-full/empty flags, lookahead read port,
// single-cycle flush and sticky overflow/underflow error flags.
module buf_que_flush #(
    parameter int unsigned SIZE_BIT  = 3,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AF_MARGIN = 1,
    parameter int unsigned AE_MARGIN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                read_flag,
    output logic [WIDTH-1:0]    read_data,
    output logic [WIDTH-1:0]    read_data_next,
    input  logic                write_flag,
    input  logic [WIDTH-1:0]    write_data,
    output logic                empty,
    output logic                full,
    output logic                almost_empty,
    output logic                almost_full,
    output logic [SIZE_BIT:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned SIZE = 1 << SIZE_BIT;

    typedef logic [SIZE_BIT-1:0] ptr_t;
    typedef logic [SIZE_BIT:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(SIZE);
    localparam cnt_t AF_LEVEL = cnt_t'(SIZE - AF_MARGIN);
    localparam cnt_t AE_LEVEL = cnt_t'(AE_MARGIN);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] mem_d [SIZE];
    ptr_t             read_ptr_q, read_ptr_d;
    ptr_t             write_ptr_q, write_ptr_d;
    cnt_t             count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rd_ok;
    logic             wr_ok;
    ptr_t             read_ptr_inc;
    ptr_t             write_ptr_inc;

    // Status decode straight from registered state
    assign empty         = (count_q == '0);
    assign full          = (count_q == CNT_FULL);
    assign almost_empty  = (count_q <= AE_LEVEL);
    assign almost_full   = (count_q >= AF_LEVEL);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    assign read_ptr_inc  = read_ptr_q + ptr_t'(1);
    assign write_ptr_inc = write_ptr_q + ptr_t'(1);

    assign read_data      = empty ? '0 : mem_q[read_ptr_q];
    assign read_data_next = (count_q < cnt_t'(2)) ? '0 : mem_q[read_ptr_inc];

    // A full queue still takes a write when a read frees a slot in the same cycle
    assign rd_ok = read_flag && !empty;
    assign wr_ok = write_flag && (!full || rd_ok);

    // Next-state: flush wins over normal traffic and leaves the error flags alone
    always_comb begin
        mem_d       = mem_q;
        read_ptr_d  = read_ptr_q;
        write_ptr_d = write_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            read_ptr_d  = '0;
            write_ptr_d = '0;
            count_d     = '0;
        end else begin
            if (write_flag && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (read_flag && empty) begin
                underflow_d = 1'b1;
            end
            if (wr_ok) begin
                mem_d[write_ptr_q] = write_data;
                write_ptr_d        = write_ptr_inc;
            end
            if (rd_ok) begin
                read_ptr_d = read_ptr_inc;
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + cnt_t'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                mem_q[i] <= '0;
            end
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            read_ptr_q  <= read_ptr_d;
            write_ptr_q <= write_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
